// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 1280x1024@60 timing constants and lock FSM state type
//
// Purpose: timing values shared by the VGA display generator and the sync
// decoder, plus the lock-state encoding and the packed RGB width.
// Ports: none (package).
package vga_timing_pkg;

  localparam int VGA_H_SYNC   = 112;
  localparam int VGA_H_BACK   = 248;
  localparam int VGA_H_ACTIVE = 1280;
  localparam int VGA_H_FRONT  = 48;
  localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;

  localparam int VGA_V_SYNC   = 3;
  localparam int VGA_V_BACK   = 38;
  localparam int VGA_V_ACTIVE = 1024;
  localparam int VGA_V_FRONT  = 1;
  localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;

  // Offset of the first active sample/line counted from the sync assertion.
  localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_LOCK_FRAMES = 2;
  localparam int RGB12_W         = 12;

  typedef enum logic [1:0] {
    LS_SEARCH  = 2'd0,
    LS_ACQUIRE = 2'd1,
    LS_LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - saturating position counter with length measurement
//
// Purpose: tracks the index along one axis (samples within a line, or lines
// within a frame) and reports the length of the span that just ended.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   en            advance the counter this cycle
//   restart       start a new span (index 0) when enabled
//   idx           index of the current cycle (cnt when not enabled)
//   len           cnt+1 saturated: length of the span ending now
//   wrap          en && restart: a span boundary is being taken
//   seen          at least one boundary taken since reset
module vga_axis_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         restart,
  output logic [W-1:0] idx,
  output logic [W-1:0] len,
  output logic         wrap,
  output logic         seen
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt;

  // Holds at MAX instead of wrapping so an overlong span still reads as bad.
  always_comb begin
    len = (cnt == MAX) ? MAX : cnt + W'(1);
    idx = cnt;
    if (en) idx = restart ? '0 : len;
  end

  assign wrap = en & restart;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (en) begin
      cnt <= idx;
      if (restart) seen <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side timing recovery, lock FSM and pixel probe
//
// Purpose: recovers pixel coordinates from an HS/VS/RGB stream, measures line
// and frame length, locks onto the expected timing and captures one pixel.
// Ports:
//   CLK, RESET_N                  pixel clock, synchronous active-low reset
//   VGA_HS, VGA_VS                sync inputs (asserted level SYNC_POL)
//   VGA_RED/GREEN/BLUE            4-bit colour inputs
//   PROBE_X, PROBE_Y              probe coordinate (latched at frame start)
//   REC_X, REC_Y, REC_ACTIVE      recovered active coordinate, 1-cycle latency
//   H_TOTAL, V_TOTAL              last measured line / frame length
//   LOCKED, TIMING_ERR            lock status, sticky timing error
//   PROBE_RGB, PROBE_VALID        captured pixel and its 1-cycle strobe
//   FRAME_DONE                    1-cycle pulse per completed frame
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL_EXP = VGA_H_TOTAL,
  parameter int   V_TOTAL_EXP = VGA_V_TOTAL,
  parameter int   H_ACT_START = VGA_H_ACT_START,
  parameter int   V_ACT_START = VGA_V_ACT_START,
  parameter int   H_ACT       = VGA_H_ACTIVE,
  parameter int   V_ACT       = VGA_V_ACTIVE,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               VGA_HS,
  input  logic               VGA_VS,
  input  logic [3:0]         VGA_RED,
  input  logic [3:0]         VGA_GREEN,
  input  logic [3:0]         VGA_BLUE,
  input  logic [10:0]        PROBE_X,
  input  logic [10:0]        PROBE_Y,
  output logic [10:0]        REC_X,
  output logic [10:0]        REC_Y,
  output logic               REC_ACTIVE,
  output logic [11:0]        H_TOTAL,
  output logic [10:0]        V_TOTAL,
  output logic               LOCKED,
  output logic               TIMING_ERR,
  output logic [RGB12_W-1:0] PROBE_RGB,
  output logic               PROBE_VALID,
  output logic               FRAME_DONE
);

  localparam logic [11:0] HX_FIRST = 12'(H_ACT_START);
  localparam logic [11:0] HX_LAST  = 12'(H_ACT_START + H_ACT - 1);
  localparam logic [10:0] VY_FIRST = 11'(V_ACT_START);
  localparam logic [10:0] VY_LAST  = 11'(V_ACT_START + V_ACT - 1);
  localparam logic [11:0] H_EXP    = 12'(H_TOTAL_EXP);
  localparam logic [10:0] V_EXP    = 11'(V_TOTAL_EXP);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  logic hs_on, vs_on, hs_prev, vs_prev, hs_edge, vs_edge;

  assign hs_on   = (VGA_HS == SYNC_POL);
  assign vs_on   = (VGA_VS == SYNC_POL);
  assign hs_edge = hs_on & ~hs_prev;
  // VS is only looked at on line starts; a VS edge between line starts is ignored.
  assign vs_edge = hs_edge & vs_on & ~vs_prev;

  logic [11:0] hidx, h_len;
  logic [10:0] vidx, v_len;
  logic        h_wrap, h_seen, v_wrap, v_seen;

  vga_axis_counter #(.W(12)) u_hcnt (
    .clk     (CLK),
    .reset_n (RESET_N),
    .en      (1'b1),
    .restart (hs_edge),
    .idx     (hidx),
    .len     (h_len),
    .wrap    (h_wrap),
    .seen    (h_seen)
  );

  vga_axis_counter #(.W(11)) u_vcnt (
    .clk     (CLK),
    .reset_n (RESET_N),
    .en      (hs_edge),
    .restart (vs_edge),
    .idx     (vidx),
    .len     (v_len),
    .wrap    (v_wrap),
    .seen    (v_seen)
  );

  logic        bad_line, frame_bad, line_bad_q;
  logic        active_now, probe_hit;
  logic [10:0] rx, ry, probe_x_q, probe_y_q;

  // The first line start after reset closes no measured line.
  assign bad_line  = h_wrap & h_seen & (h_len != H_EXP);
  // The line ending on the frame-start cycle belongs to the closing frame.
  assign frame_bad = line_bad_q | bad_line | (v_len != V_EXP);

  assign active_now = (hidx >= HX_FIRST) && (hidx <= HX_LAST) &&
                      (vidx >= VY_FIRST) && (vidx <= VY_LAST);
  assign rx = 11'(hidx - HX_FIRST);
  assign ry = vidx - VY_FIRST;

  lock_state_t state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        err_set;

  assign probe_hit = (state_q == LS_LOCKED) && active_now &&
                     (rx == probe_x_q) && (ry == probe_y_q);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_set = 1'b0;
    case (state_q)
      LS_SEARCH: begin
        if (vs_edge) begin
          state_d = LS_ACQUIRE;
          good_d  = '0;
        end
      end
      LS_ACQUIRE: begin
        if (vs_edge) begin
          if (frame_bad) begin
            good_d = '0;
          end else if (good_q + 4'd1 >= LOCK_N) begin
            state_d = LS_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      LS_LOCKED: begin
        // A bad line drops lock at once; the frame check waits for frame start.
        if (bad_line || (vs_edge && frame_bad)) begin
          state_d = LS_SEARCH;
          err_set = 1'b1;
        end
      end
      default: state_d = LS_SEARCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      line_bad_q  <= 1'b0;
      probe_x_q   <= '0;
      probe_y_q   <= '0;
      state_q     <= LS_SEARCH;
      good_q      <= '0;
      REC_X       <= '0;
      REC_Y       <= '0;
      REC_ACTIVE  <= 1'b0;
      H_TOTAL     <= '0;
      V_TOTAL     <= '0;
      LOCKED      <= 1'b0;
      TIMING_ERR  <= 1'b0;
      PROBE_RGB   <= '0;
      PROBE_VALID <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      hs_prev <= hs_on;
      if (hs_edge) vs_prev <= vs_on;

      if (vs_edge) begin
        line_bad_q <= 1'b0;
        probe_x_q  <= PROBE_X;
        probe_y_q  <= PROBE_Y;
      end else if (bad_line) begin
        line_bad_q <= 1'b1;
      end

      state_q <= state_d;
      good_q  <= good_d;

      REC_ACTIVE <= active_now;
      if (active_now) begin
        REC_X <= rx;
        REC_Y <= ry;
      end

      if (h_wrap && h_seen) H_TOTAL <= h_len;
      if (v_wrap) V_TOTAL <= v_len;
      FRAME_DONE <= v_wrap & v_seen;

      LOCKED     <= (state_d == LS_LOCKED);
      TIMING_ERR <= TIMING_ERR | err_set;

      PROBE_VALID <= probe_hit;
      if (probe_hit) PROBE_RGB <= {VGA_RED, VGA_GREEN, VGA_BLUE};
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed self-checking bench for vga_sync_decoder
//
// Purpose: drives a scaled-down VGA stream (40 clocks x 30 lines, active
// 20x20 starting at sample 10 / line 5) and checks lock, measurement,
// coordinates, probe capture, error handling and reset.
// Ports: none (top-level bench).
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HSW = 4;
  localparam int VT  = 30;
  localparam int VSW = 2;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        VGA_HS = 1'b0;
  logic        VGA_VS = 1'b0;
  logic [3:0]  VGA_RED = '0, VGA_GREEN = '0, VGA_BLUE = '0;
  logic [10:0] PROBE_X = 11'd10, PROBE_Y = 11'd10;
  logic [10:0] REC_X, REC_Y, V_TOTAL;
  logic [11:0] H_TOTAL, PROBE_RGB;
  logic        REC_ACTIVE, LOCKED, TIMING_ERR, PROBE_VALID, FRAME_DONE;

  always #5 CLK = ~CLK;

  vga_sync_decoder #(
    .H_TOTAL_EXP (40),
    .V_TOTAL_EXP (30),
    .H_ACT_START (10),
    .V_ACT_START (5),
    .H_ACT       (20),
    .V_ACT       (20),
    .SYNC_POL    (1'b1),
    .LOCK_FRAMES (2)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_RED     (VGA_RED),
    .VGA_GREEN   (VGA_GREEN),
    .VGA_BLUE    (VGA_BLUE),
    .PROBE_X     (PROBE_X),
    .PROBE_Y     (PROBE_Y),
    .REC_X       (REC_X),
    .REC_Y       (REC_Y),
    .REC_ACTIVE  (REC_ACTIVE),
    .H_TOTAL     (H_TOTAL),
    .V_TOTAL     (V_TOTAL),
    .LOCKED      (LOCKED),
    .TIMING_ERR  (TIMING_ERR),
    .PROBE_RGB   (PROBE_RGB),
    .PROBE_VALID (PROBE_VALID),
    .FRAME_DONE  (FRAME_DONE)
  );

  int checks = 0;
  int errors = 0;

  int cur_line = -1, cur_pix = -1, vs_cnt = 0, fd_cnt = 0, pv_cnt = 0;
  int rise_line = -1, rise_pix = -1, last_line = -1, last_pix = -1;
  int lock_vs = -1, lock_line = -1, lock_pix = -1, unlock_line = -1, unlock_pix = -1;
  logic [11:0] pv_rgb = '0;
  logic [10:0] rise_x = '0, rise_y = '0, last_x = '0, last_y = '0;
  logic        ra_prev = 1'b0, lk_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs after this edge reflect the sample presented as (cur_line, cur_pix).
  task automatic tick();
    @(posedge CLK);
    #1;
    if (FRAME_DONE) fd_cnt++;
    if (PROBE_VALID) begin
      pv_cnt++;
      pv_rgb = PROBE_RGB;
    end
    if (REC_ACTIVE && !ra_prev && rise_line < 0) begin
      rise_line = cur_line;
      rise_pix  = cur_pix;
      rise_x    = REC_X;
      rise_y    = REC_Y;
    end
    if (REC_ACTIVE) begin
      last_line = cur_line;
      last_pix  = cur_pix;
      last_x    = REC_X;
      last_y    = REC_Y;
    end
    if (LOCKED && !lk_prev) begin
      lock_vs   = vs_cnt;
      lock_line = cur_line;
      lock_pix  = cur_pix;
    end
    if (!LOCKED && lk_prev) begin
      unlock_line = cur_line;
      unlock_pix  = cur_pix;
    end
    ra_prev = REC_ACTIVE;
    lk_prev = LOCKED;
  endtask

  // Probe pixel (x=10,y=10) sits at sample 20 of line 15 and carries 0xA5C.
  task automatic run_lines(input int first, input int last, input int bad_ln, input int bad_len);
    int len;
    for (int l = first; l <= last; l++) begin
      len = (l == bad_ln) ? bad_len : HT;
      for (int p = 0; p < len; p++) begin
        cur_line = l;
        cur_pix  = p;
        VGA_HS   = (p < HSW);
        VGA_VS   = (l < VSW);
        {VGA_RED, VGA_GREEN, VGA_BLUE} = (l == 15 && p == 20) ? 12'hA5C : 12'h111;
        if (l == 0 && p == 0) vs_cnt++;
        tick();
      end
    end
  endtask

  task automatic run_frame();
    run_lines(0, VT - 1, -1, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_outputs",
        {2'b00, REC_X, REC_Y, REC_ACTIVE, H_TOTAL, V_TOTAL, LOCKED, TIMING_ERR,
         PROBE_RGB, PROBE_VALID, FRAME_DONE}, 64'd0);
    RESET_N = 1'b1;
    repeat (2) tick();

    // Nominal: lock at the 3rd frame start, capture in frame 3
    run_frame();
    run_frame();
    run_frame();
    chk("lock_vs_edge", lock_vs, 3);
    chk("lock_line", lock_line, 0);
    chk("lock_pix", lock_pix, 0);
    chk("h_total_nominal", H_TOTAL, 40);
    chk("v_total_nominal", V_TOTAL, 30);
    chk("frame_done_count_first", fd_cnt, 2);
    chk("timing_err_nominal", TIMING_ERR, 0);
    chk("probe_count_f3", pv_cnt, 1);
    chk("probe_rgb_f3", pv_rgb, 12'hA5C);
    chk("first_active_line", rise_line, 5);
    chk("first_active_pix", rise_pix, 10);
    chk("first_active_xy", {rise_x, rise_y}, 22'd0);
    chk("last_active_line", last_line, 24);
    chk("last_active_pix", last_pix, 29);
    chk("last_active_x", last_x, 1279 - 1260);
    chk("last_active_y", last_y, 19);

    // Mid-frame probe change only applies from the next frame
    pv_cnt = 0;
    fd_cnt = 0;
    pv_rgb = '0;
    run_lines(0, 9, -1, 0);
    PROBE_X = 11'd20;
    PROBE_Y = 11'd0;
    run_lines(10, VT - 1, -1, 0);
    chk("probe_count_f4", pv_cnt, 1);
    chk("probe_rgb_f4", pv_rgb, 12'hA5C);
    pv_cnt = 0;
    run_frame();
    chk("probe_outside_never", pv_cnt, 0);
    chk("frame_done_per_frame", fd_cnt, 2);
    chk("locked_steady", LOCKED, 1);

    // One short line while locked
    PROBE_X = 11'd10;
    PROBE_Y = 11'd10;
    unlock_line = -1;
    unlock_pix  = -1;
    run_lines(0, 10, 10, HT - 1);
    run_lines(11, 11, -1, 0);
    chk("short_line_h_total", H_TOTAL, 39);
    chk("short_line_err", TIMING_ERR, 1);
    chk("short_line_unlock", LOCKED, 0);
    chk("unlock_line", unlock_line, 11);
    chk("unlock_pix", unlock_pix, 0);
    run_lines(12, VT - 1, -1, 0);

    // Relock: one frame to leave SEARCH, then two good frames
    vs_cnt  = 0;
    lock_vs = -1;
    run_frame();
    run_frame();
    chk("no_early_relock", LOCKED, 0);
    run_frame();
    chk("relock_vs_edge", lock_vs, 3);
    chk("err_sticky_relock", TIMING_ERR, 1);
    chk("relocked", LOCKED, 1);

    // HS held off for 5000 clocks: counter saturates, next line is bad
    VGA_HS = 1'b0;
    VGA_VS = 1'b0;
    cur_line = -1;
    repeat (5000) tick();
    run_lines(VT - 1, VT - 1, -1, 0);
    chk("sat_h_total", H_TOTAL, 4095);
    chk("sat_unlock", LOCKED, 0);
    chk("sat_err_sticky", TIMING_ERR, 1);

    // Relock, then a 1-cycle reset in the middle of a frame
    run_frame();
    run_frame();
    run_lines(0, 12, -1, 0);
    chk("locked_before_reset", LOCKED, 1);
    RESET_N = 1'b0;
    VGA_HS = 1'b0;
    VGA_VS = 1'b0;
    cur_line = -1;
    tick();
    chk("midframe_reset_outputs",
        {2'b00, REC_X, REC_Y, REC_ACTIVE, H_TOTAL, V_TOTAL, LOCKED, TIMING_ERR,
         PROBE_RGB, PROBE_VALID, FRAME_DONE}, 64'd0);
    RESET_N = 1'b1;
    fd_cnt  = 0;
    vs_cnt  = 0;
    lock_vs = -1;
    run_lines(13, VT - 1, -1, 0);
    run_frame();
    run_frame();
    chk("no_lock_two_edges", LOCKED, 0);
    chk("post_reset_frame_done", fd_cnt, 1);
    run_lines(0, 0, -1, 0);
    chk("post_reset_lock_vs", lock_vs, 3);
    chk("post_reset_locked", LOCKED, 1);
    chk("post_reset_v_total", V_TOTAL, 30);
    chk("post_reset_err_clear", TIMING_ERR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
